// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 3-stage pipeline: memory-access stalls
// with timeout, taken-branch fetch flush and MW->E operand forwarding selects.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_MW,
    input  logic             reg_wrMW,
    input  logic [1:0]       wb_selMW,
    input  logic             wr_enMW,
    input  logic             rd_enMW,
    input  logic             br_taken_E,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             stall_F,
    output logic             stall_MW,
    output logic             flush_F,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       acc;
    logic       timeout_hit;
    logic       stall;

    // Load data is only forwarded in the ack cycle, which the stall already guarantees.
    logic unused_wb_sel;
    assign unused_wb_sel = ^wb_selMW;

    always_comb begin
        acc         = rd_enMW | wr_enMW;
        timeout_hit = (state == ST_WAIT) & acc & ~dmem_ack
                      & (wait_cnt == 8'(MEM_TIMEOUT - 1));
        stall       = ~rst & acc & ~dmem_ack & ~timeout_hit;
    end

    always_comb begin
        dmem_req = ~rst & acc & ((state == ST_IDLE) | (state == ST_WAIT));
        stall_F  = stall;
        stall_MW = stall;
        flush_F  = ~rst & br_taken_E & ~stall;
        fwd_a    = ~rst & reg_wrMW & (rd_MW != 5'd0) & (rd_MW == rs1_E);
        fwd_b    = ~rst & reg_wrMW & (rd_MW != 5'd0) & (rd_MW == rs2_E);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (acc & ~dmem_ack) begin
                        state    <= ST_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    // Ack, timeout or a dropped request all end the wait.
                    if (~acc | dmem_ack | timeout_hit) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                        if (timeout_hit)
                            mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_E, rs2_E, rd_MW;
    logic        reg_wrMW, wr_enMW, rd_enMW, br_taken_E, dmem_ack;
    logic [1:0]  wb_selMW;
    logic        dmem_req, stall_F, stall_MW, flush_F, fwd_a, fwd_b, mem_err;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_MW(rd_MW),
        .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .wr_enMW(wr_enMW),
        .rd_enMW(rd_enMW), .br_taken_E(br_taken_E), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .stall_F(stall_F), .stall_MW(stall_MW),
        .flush_F(flush_F), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so checks land well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; rs1_E = 5'd0; rs2_E = 5'd0; rd_MW = 5'd0; reg_wrMW = 1'b0;
        wb_selMW = 2'b00; wr_enMW = 1'b0; rd_enMW = 1'b0; br_taken_E = 1'b0; dmem_ack = 1'b0;
        tick(); tick();

        // Reset forces combinational outputs low
        rd_enMW = 1'b1; br_taken_E = 1'b1; reg_wrMW = 1'b1; rd_MW = 5'd3; rs1_E = 5'd3;
        settle();
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall_F, 0);
        check("rst_flush", flush_F, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_err", mem_err, 0);
        tick();
        rst = 1'b0; rd_enMW = 1'b0; br_taken_E = 1'b0; reg_wrMW = 1'b0;

        // Zero-wait load
        rd_enMW = 1'b1; dmem_ack = 1'b1; wb_selMW = 2'b10;
        settle();
        check("zw_req", dmem_req, 1);
        check("zw_stall", stall_F, 0);
        tick();
        check("zw_cnt", stall_cnt, 0);

        // 3-cycle store
        rd_enMW = 1'b0; wr_enMW = 1'b1; dmem_ack = 1'b0; wb_selMW = 2'b00;
        settle();
        check("st_c1_stallF", stall_F, 1);
        check("st_c1_stallMW", stall_MW, 1);
        check("st_c1_req", dmem_req, 1);
        tick(); settle();
        check("st_c2_stall", stall_F, 1);
        check("st_c2_req", dmem_req, 1);
        tick();
        dmem_ack = 1'b1;
        settle();
        check("st_c3_stall", stall_F, 0);
        check("st_c3_req", dmem_req, 1);
        tick();
        wr_enMW = 1'b0; dmem_ack = 1'b0;
        settle();
        check("st_cnt", stall_cnt, 2);
        check("idle_req", dmem_req, 0);
        check("idle_stall", stall_F, 0);
        tick();

        // Forwarding
        reg_wrMW = 1'b1; rd_MW = 5'd5; rs1_E = 5'd5; rs2_E = 5'd0;
        settle();
        check("fwd1_a", fwd_a, 1);
        check("fwd1_b", fwd_b, 0);
        rs1_E = 5'd3; rs2_E = 5'd5;
        settle();
        check("fwd2_a", fwd_a, 0);
        check("fwd2_b", fwd_b, 1);
        rd_MW = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
        settle();
        check("fwd_x0_a", fwd_a, 0);
        check("fwd_x0_b", fwd_b, 0);
        reg_wrMW = 1'b0; rd_MW = 5'd7; rs1_E = 5'd7;
        settle();
        check("fwd_nowr_a", fwd_a, 0);
        tick();

        // Branch held across a 2-cycle-ack load
        br_taken_E = 1'b1; rd_enMW = 1'b1; dmem_ack = 1'b0;
        settle();
        check("br_c1_flush", flush_F, 0);
        check("br_c1_stall", stall_F, 1);
        tick();
        dmem_ack = 1'b1;
        settle();
        check("br_c2_flush", flush_F, 1);
        check("br_c2_stall", stall_F, 0);
        tick();
        br_taken_E = 1'b0; rd_enMW = 1'b0; dmem_ack = 1'b0;
        settle();
        check("br_after_flush", flush_F, 0);
        check("br_cnt", stall_cnt, 3);
        br_taken_E = 1'b1;
        settle();
        check("br_plain_flush", flush_F, 1);
        tick();
        br_taken_E = 1'b0;

        // Request dropped while waiting: back to IDLE without error
        rd_enMW = 1'b1;
        settle();
        check("drop_c1_stall", stall_F, 1);
        tick();
        rd_enMW = 1'b0;
        settle();
        check("drop_stall", stall_F, 0);
        tick();

        // Fresh access after the drop: three stall cycles, ack arrives in the timeout cycle
        rd_enMW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ackto_stall", stall_F, 1);
            tick();
        end
        dmem_ack = 1'b1;
        settle();
        check("ackto_c4_stall", stall_F, 0);
        tick();
        rd_enMW = 1'b0; dmem_ack = 1'b0;
        settle();
        check("ackto_err", mem_err, 0);
        check("ackto_cnt", stall_cnt, 7);
        tick();

        // Timeout with no ack
        rd_enMW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("to_stall", stall_F, 1);
            check("to_err_pre", mem_err, 0);
            tick();
        end
        settle();
        check("to_c4_stall", stall_F, 0);
        check("to_c4_req", dmem_req, 1);
        tick();
        rd_enMW = 1'b0;
        settle();
        check("to_err", mem_err, 1);
        check("to_cnt", stall_cnt, 10);
        tick(); tick();
        check("to_err_sticky", mem_err, 1);

        // Error does not affect the next access
        wr_enMW = 1'b1; dmem_ack = 1'b1;
        settle();
        check("post_err_stall", stall_F, 0);
        tick();
        wr_enMW = 1'b0; dmem_ack = 1'b0;

        // Reset during the second WAIT cycle
        rd_enMW = 1'b1;
        tick();
        tick();
        settle();
        check("rw_pre_stall", stall_F, 1);
        rst = 1'b1; br_taken_E = 1'b1; reg_wrMW = 1'b1; rd_MW = 5'd9; rs1_E = 5'd9;
        settle();
        check("rw_req", dmem_req, 0);
        check("rw_stall", stall_F, 0);
        check("rw_flush", flush_F, 0);
        check("rw_fwd", fwd_a, 0);
        tick();
        rst = 1'b0; br_taken_E = 1'b0; reg_wrMW = 1'b0; rd_enMW = 1'b0;
        settle();
        check("rw_cnt", stall_cnt, 0);
        check("rw_err", mem_err, 0);
        check("rw_idle_req", dmem_req, 0);

        // FSM is in IDLE: a new unacked access gets the full three stall cycles
        rd_enMW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rw_new_stall", stall_F, 1);
            tick();
        end
        settle();
        check("rw_new_release", stall_F, 0);
        tick();
        rd_enMW = 1'b0;
        settle();
        check("rw_new_cnt", stall_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
